if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the five-stage pipeline: owns the PC, fetches from
//  instruction memory over a req/gnt + rvalid interface, and drives the IF/ID
//  pipeline register whose if_id_instr feeds the decode stage (ImmGen, control).
//  Handles ID back-pressure with a 1-entry skid buffer and EX redirects by flush.
// PARAMETERS
//  RESET_PC  32'h0000_0000  address of first fetch after reset
//  NOP_INSTR 32'h0000_0013  value of if_id_instr when if_id_valid=0 (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address, bits[1:0]=00 always
//  imem_gnt     in   1   request accepted this cycle (imem_req && imem_gnt)
//  imem_rvalid  in   1   read data valid; >=1 cycle after gnt, exactly one per gnt
//  imem_rdata   in   32  instruction word
//  id_stall     in   1   ID cannot take a new instruction this cycle
//  redirect     in   1   EX: taken branch / Jal / Jalr, flush IF and IF/ID
//  redirect_pc  in   32  new fetch address; bits[1:0] ignored (forced 00)
//  if_id_valid  out  1   IF/ID holds a live instruction
//  if_id_pc     out  32  PC of if_id_instr
//  if_id_pc4    out  32  if_id_pc + 4 (mod 2^32)
//  if_id_instr  out  32  instruction to decode
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, state=REQ, skid empty, if_id_valid=0,
//   if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0; imem_req=0 while rst=1.
//  One outstanding fetch max. imem_addr = pc. pc <= pc+4 on gnt (wraps at 2^32).
//  accept = !if_id_valid || !id_stall (IF/ID may load this cycle).
//  States:
//   REQ : imem_req=1. gnt -> WAIT. imem_req/addr may change while ungranted.
//   WAIT: rvalid && accept -> load IF/ID; imem_req=1 same cycle (combinational)
//         for next pc; gnt -> WAIT, else -> REQ.
//         rvalid && !accept -> load skid, imem_req=0, -> HOLD.
//   HOLD: imem_req=0. When !id_stall: skid -> IF/ID, skid empty, -> REQ.
//   DROP: imem_req=0; wait for rvalid of a squashed fetch, discard it -> REQ.
//  ID consumes when if_id_valid && !id_stall; if no new data, if_id_valid<=0,
//   if_id_instr<=NOP_INSTR. When id_stall && if_id_valid: IF/ID holds.
//  Redirect (highest priority, overrides stall and rvalid):
//   if_id_valid<=0, skid emptied, pc<=redirect_pc&~3; request not issued in
//   that cycle (imem_req=0). Next state: WAIT w/o rvalid this cycle -> DROP;
//   otherwise (REQ/HOLD/DROP-done/WAIT with rvalid) -> REQ. rvalid data in the
//   redirect cycle is discarded. Redirect while in DROP stays in DROP.
//  Instructions leave in program order; none lost, none duplicated.
//  Latency: gnt same cycle + rvalid next cycle => 1 instr/cycle, IF/ID valid one
//   cycle after rvalid edge. Reset mid-fetch abandons it; the pending rvalid
//   is the memory's to drop (imem reset together with this block).
// TESTING
//  1 rst 2 cycles -> if_id_valid=0, if_id_instr=0x00000013, then imem_req=1,
//    imem_addr=0x0.
//  2 zero-wait imem, words 0x00200093,0x00100113,0x002081B3 -> IF/ID shows
//    pc 0,4,8 with those words on consecutive cycles, pc4 = 4,8,12.
//  3 id_stall=1 for 3 cycles while fetch of 0x8 returns -> skid holds it,
//    imem_req=0, IF/ID keeps pc 0x4; on release pc 0x8 then 0xC, no gaps/dups.
//  4 redirect=1, redirect_pc=0x103 while fetch of 0x10 in WAIT -> if_id_valid=0,
//    late rvalid discarded, next imem_addr=0x100, next IF/ID pc=0x100.
//  5 redirect and id_stall same cycle with rvalid -> redirect wins, IF/ID
//    invalid next cycle, rdata dropped; pc=0xFFFFFFFC fetch -> next addr 0x0.
//  6 rst asserted in HOLD with skid full -> all outputs at reset values next
//    cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt + rvalid bus, and
// drives the IF/ID register with a one-entry skid buffer for ID back-pressure.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] skid_pc_q, skid_instr_q;
    logic        valid_q, valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic accept;
    logic req;
    logic fire;
    logic load_mem;
    logic load_skid;
    logic load_from_skid;

    always_comb begin
        accept         = !valid_q || !id_stall;
        state_d        = state_q;
        req            = 1'b0;
        load_mem       = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;

        case (state_q)
            S_REQ: begin
                req = 1'b1;
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (accept) begin
                        // Back-to-back: issue the next fetch in the cycle the data lands.
                        req      = 1'b1;
                        load_mem = 1'b1;
                        state_d  = imem_gnt ? S_WAIT : S_REQ;
                    end else begin
                        load_skid = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    load_from_skid = 1'b1;
                    state_d        = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // A redirect with a fetch still in flight must swallow its late response.
        if (redirect) begin
            req            = 1'b0;
            load_mem       = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
            state_d        = ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid)
                             ? S_DROP : S_REQ;
        end

        if (rst) req = 1'b0;

        fire = req && imem_gnt;

        if (redirect)  pc_d = redirect_pc & ~32'h3;
        else if (fire) pc_d = pc_q + 32'd4;
        else           pc_d = pc_q;

        valid_d    = valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        if (redirect) begin
            valid_d    = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (load_mem) begin
            valid_d    = 1'b1;
            id_pc_d    = fetch_pc_q;
            id_pc4_d   = fetch_pc_q + 32'd4;
            id_instr_d = imem_rdata;
        end else if (load_from_skid) begin
            valid_d    = 1'b1;
            id_pc_d    = skid_pc_q;
            id_pc4_d   = skid_pc_q + 32'd4;
            id_instr_d = skid_instr_q;
        end else if (valid_q && !id_stall) begin
            valid_d    = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
        end
    end

    // Datapath-only registers: qualified by FSM state, so no reset needed.
    always_ff @(posedge clk) begin
        if (fire) fetch_pc_q <= pc_q;
        if (load_skid) begin
            skid_pc_q    <= fetch_pc_q;
            skid_instr_q <= imem_rdata;
        end
    end

    assign imem_req    = req;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = id_pc_q;
    assign if_id_pc4   = id_pc4_q;
    assign if_id_instr = id_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Cycle-by-cycle directed vectors for if_stage: each row drives the memory/ID/EX
// inputs for one cycle and lists the outputs expected in that same cycle.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic        chkpc;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } vec_t;

    localparam int NV = 28;
    localparam logic [31:0] NOP = 32'h0000_0013;

    vec_t tbl [NV];
    int   nv;
    int   errors;
    int   checks;

    task automatic add(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rdr, input logic [31:0] rpc,
                       input logic rq, input logic [31:0] ad, input logic v, input logic cp,
                       input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins);
        vec_t e;
        e.rst = r;  e.gnt = g;  e.rv = rv;  e.rdata = rd;  e.stall = st;
        e.redir = rdr;  e.rpc = rpc;  e.req = rq;  e.addr = ad;  e.vld = v;
        e.chkpc = cp;  e.pc = pc;  e.pc4 = pc4;  e.instr = ins;
        tbl[nv] = e;
        nv++;
    endtask

    task automatic check(input int row, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got 0x%08h expected 0x%08h", row, name, act, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nv     = 0;

        //  rst gnt rv rdata          stl rdr rpc             req addr          vld chk pc             pc4            instr
        // reset state, then zero-wait streaming of three instructions
        add(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         0, 1, 32'h0,        32'h0,        NOP);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h0,         0, 0, 32'h0,        32'h0,        NOP);
        add(0, 1, 1, 32'h00200093,  0, 0, 32'h0,          1, 32'h4,         0, 0, 32'h0,        32'h0,        NOP);
        add(0, 1, 1, 32'h00100113,  0, 0, 32'h0,          1, 32'h8,         1, 0, 32'h0,        32'h4,        32'h00200093);
        // ID stalls three cycles as the fetch of 0x8 returns: skid holds it
        add(0, 0, 1, 32'h002081B3,  1, 0, 32'h0,          0, 32'hC,         1, 0, 32'h4,        32'h8,        32'h00100113);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'hC,         1, 0, 32'h4,        32'h8,        32'h00100113);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'hC,         1, 0, 32'h4,        32'h8,        32'h00100113);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'hC,         1, 0, 32'h4,        32'h8,        32'h00100113);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'hC,         1, 0, 32'h8,        32'hC,        32'h002081B3);
        add(0, 0, 1, 32'h00000333,  0, 0, 32'h0,          1, 32'h10,        0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h10,        1, 0, 32'hC,        32'h10,       32'h00000333);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h10,        0, 0, 32'h0,        32'h0,        NOP);
        // redirect to 0x103 while fetch of 0x10 is outstanding; late rvalid dropped
        add(0, 0, 0, 32'h0,         0, 1, 32'h103,        0, 32'h14,        0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 1, 32'h11111111,  0, 0, 32'h0,          0, 32'h100,       0, 0, 32'h0,        32'h0,        NOP);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h100,       0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 1, 32'h22222222,  0, 0, 32'h0,          1, 32'h104,       0, 0, 32'h0,        32'h0,        NOP);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h104,       1, 0, 32'h100,      32'h104,      32'h22222222);
        add(0, 0, 1, 32'h33333333,  0, 0, 32'h0,          1, 32'h108,       0, 0, 32'h0,        32'h0,        NOP);
        // redirect + stall + rvalid together, then fetch across the 2^32 wrap
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h108,       1, 0, 32'h104,      32'h108,      32'h33333333);
        add(0, 0, 1, 32'h44444444,  1, 1, 32'hFFFFFFFC,   0, 32'h10C,       1, 0, 32'h104,      32'h108,      32'h33333333);
        add(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFFFFFC,  0, 0, 32'h0,        32'h0,        NOP);
        add(0, 1, 1, 32'h55555555,  1, 0, 32'h0,          1, 32'h0,         0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 1, 32'h00200093,  1, 0, 32'h0,          0, 32'h4,         1, 0, 32'hFFFFFFFC, 32'h0,        32'h55555555);
        // reset while HOLD has a full skid
        add(1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h4,         1, 0, 32'hFFFFFFFC, 32'h0,        32'h55555555);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h0,         0, 1, 32'h0,        32'h0,        NOP);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h0,         0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 1, 32'hAAAA0001,  0, 0, 32'h0,          1, 32'h4,         0, 0, 32'h0,        32'h0,        NOP);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h4,         1, 0, 32'h0,        32'h4,        32'hAAAA0001);

        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < nv; i++) begin
            #1;
            rst         = tbl[i].rst;
            imem_gnt    = tbl[i].gnt;
            imem_rvalid = tbl[i].rv;
            imem_rdata  = tbl[i].rdata;
            id_stall    = tbl[i].stall;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            #2;
            check(i, "imem_req",    {31'b0, imem_req},    {31'b0, tbl[i].req});
            check(i, "imem_addr",   imem_addr,            tbl[i].addr);
            check(i, "if_id_valid", {31'b0, if_id_valid}, {31'b0, tbl[i].vld});
            check(i, "if_id_instr", if_id_instr,          tbl[i].instr);
            if (tbl[i].vld || tbl[i].chkpc) begin
                check(i, "if_id_pc",  if_id_pc,  tbl[i].pc);
                check(i, "if_id_pc4", if_id_pc4, tbl[i].pc4);
            end
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
